// File: rtl/alu_mdu_if.sv
// Execute-stage bundle between the pipeline and alu_mdu: ALU operands and
// select, MDU start/busy/done handshake, and the HI/LO read-back.
interface alu_mdu_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = 5,
  parameter int SHAMT_WIDTH = 5
);
  logic [DATA_WIDTH-1:0]  operand1;
  logic [DATA_WIDTH-1:0]  operand2;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [SEL_WIDTH-1:0]   opSel;
  logic                   start;
  logic [DATA_WIDTH-1:0]  result;
  logic                   overflow;
  logic                   busy;
  logic                   done;
  logic [DATA_WIDTH-1:0]  hi;
  logic [DATA_WIDTH-1:0]  lo;

  modport master (
    output operand1, operand2, shamt, opSel, start,
    input  result, overflow, busy, done, hi, lo
  );

  modport slave (
    input  operand1, operand2, shamt, opSel, start,
    output result, overflow, busy, done, hi, lo
  );
endinterface

// File: rtl/alu_mdu.sv
// Execute-stage ALU with an iterative multiply/divide unit and HI/LO registers.
// ALU_SIGNED_OVF_EN selects signed ADD/SUB overflow; default is unsigned carry/borrow.
module alu_mdu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = 5,
  parameter int SHAMT_WIDTH = 5
) (
  input logic        clk,
  input logic        rst,
  alu_mdu_if.slave   bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [SEL_WIDTH-1:0] OP_ADD   = SEL_WIDTH'(0);
  localparam logic [SEL_WIDTH-1:0] OP_SUB   = SEL_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0] OP_AND   = SEL_WIDTH'(2);
  localparam logic [SEL_WIDTH-1:0] OP_OR    = SEL_WIDTH'(3);
  localparam logic [SEL_WIDTH-1:0] OP_SLT   = SEL_WIDTH'(4);
  localparam logic [SEL_WIDTH-1:0] OP_SGT   = SEL_WIDTH'(5);
  localparam logic [SEL_WIDTH-1:0] OP_NOR   = SEL_WIDTH'(6);
  localparam logic [SEL_WIDTH-1:0] OP_XOR   = SEL_WIDTH'(7);
  localparam logic [SEL_WIDTH-1:0] OP_SLL   = SEL_WIDTH'(8);
  localparam logic [SEL_WIDTH-1:0] OP_SRL   = SEL_WIDTH'(9);
  localparam logic [SEL_WIDTH-1:0] OP_SRA   = SEL_WIDTH'(10);
  localparam logic [SEL_WIDTH-1:0] OP_SLTU  = SEL_WIDTH'(11);
  localparam logic [SEL_WIDTH-1:0] OP_MULT  = SEL_WIDTH'(12);
  localparam logic [SEL_WIDTH-1:0] OP_DIVU  = SEL_WIDTH'(15);
  localparam logic [SEL_WIDTH-1:0] OP_MFHI  = SEL_WIDTH'(16);
  localparam logic [SEL_WIDTH-1:0] OP_MFLO  = SEL_WIDTH'(17);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  logic [W-1:0]           a, b;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [SEL_WIDTH-1:0]   sel;
  logic [W-1:0]           result, hi_r, lo_r;
  logic                   overflow, ovf_add, ovf_sub;
  logic [W:0]             sum, diff;

  assign a     = bus.operand1;
  assign b     = bus.operand2;
  assign shamt = bus.shamt;
  assign sel   = bus.opSel;
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};

`ifdef ALU_SIGNED_OVF_EN
  assign ovf_add = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
  assign ovf_sub = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
`else
  assign ovf_add = sum[W];
  assign ovf_sub = diff[W];
`endif

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (sel)
      OP_ADD:  begin result = sum[W-1:0];  overflow = ovf_add; end
      OP_SUB:  begin result = diff[W-1:0]; overflow = ovf_sub; end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SLT:  result = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SGT:  result = {{(W-1){1'b0}}, $signed(a) > $signed(b)};
      OP_NOR:  result = ~(a | b);
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = b << shamt;
      OP_SRL:  result = b >> shamt;
      OP_SRA:  result = $signed(b) >>> shamt;
      OP_SLTU: result = {{(W-1){1'b0}}, a < b};
      OP_MFHI: result = hi_r;
      OP_MFLO: result = lo_r;
      default: result = '0;
    endcase
  end

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          busy_r, done_r, is_div, neg_res, neg_rem, div0;
  logic [W-1:0]  m_reg, p_hi, p_lo;
  logic          launch, last, sgn, a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    mul_sum, div_shift, div_trial;
  logic [2*W-1:0] prod_neg;

  assign launch = (state == S_IDLE) && bus.start && (sel >= OP_MULT) && (sel <= OP_DIVU);
  assign last   = (cnt == CW'(W - 1));
  assign sgn    = ~sel[0];
  assign a_neg  = sgn & a[W-1];
  assign b_neg  = sgn & b[W-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  // p_hi holds the partial product / running remainder; p_lo the multiplier / quotient bits
  assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m_reg} : '0);
  assign div_shift = {p_hi, p_lo[W-1]};
  assign div_trial = div_shift - {1'b0, m_reg};
  assign prod_neg  = -{p_hi, p_lo};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (launch) state_nx = S_RUN;
      S_RUN:   if (last) state_nx = S_FIX;
      S_FIX:   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0; busy_r <= 1'b0; done_r <= 1'b0;
      is_div <= 1'b0; neg_res <= 1'b0; neg_rem <= 1'b0; div0 <= 1'b0;
      m_reg <= '0; p_hi <= '0; p_lo <= '0; hi_r <= '0; lo_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: if (launch) begin
          is_div  <= sel[1];
          neg_res <= a_neg ^ b_neg;
          neg_rem <= a_neg;
          div0    <= (b == '0);
          m_reg   <= sel[1] ? b_mag : a_mag;
          p_lo    <= sel[1] ? a_mag : b_mag;
          p_hi    <= '0;
          cnt     <= '0;
          busy_r  <= 1'b1;
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            p_hi <= div_trial[W] ? div_shift[W-1:0] : div_trial[W-1:0];
            p_lo <= {p_lo[W-2:0], ~div_trial[W]};
          end else begin
            {p_hi, p_lo} <= {mul_sum, p_lo[W-1:1]};
          end
        end
        S_FIX: begin
          busy_r <= 1'b0;
          // divide-by-zero quotient stays all ones; remainder already equals |dividend|
          if (!is_div) begin
            if (neg_res) {p_hi, p_lo} <= prod_neg;
          end else begin
            if (neg_res && !div0) p_lo <= -p_lo;
            if (neg_rem)          p_hi <= -p_hi;
          end
        end
        S_DONE: begin
          hi_r   <= p_hi;
          lo_r   <= p_lo;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.result   = result;
  assign bus.overflow = overflow;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: combinational ops checked directly, MDU results
// through a scoreboard popped on each done pulse (also checks latency).
module tb_alu_mdu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  alu_mdu_if #(.DATA_WIDTH(W), .SEL_WIDTH(5), .SHAMT_WIDTH(5)) bus ();
  alu_mdu #(.DATA_WIDTH(W), .SEL_WIDTH(5), .SHAMT_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] exp;
    int          launch;
  } txn_t;

  txn_t scoreboard[$];
  int checks = 0, errors = 0, cyc = 0, done_seen = 0, done_expected = 0;

`ifdef ALU_SIGNED_OVF_EN
  localparam logic SIGNED_OVF = 1'b1;
`else
  localparam logic SIGNED_OVF = 1'b0;
`endif

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        sa, sb;
    logic signed [31:0] q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      5'd12: return sa * sb;
      5'd13: return {32'h0, a} * {32'h0, b};
      5'd14: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    txn_t t;
    if (rst && bus.done) begin
      done_seen++;
      check("done_count", 64'(done_seen), 64'(done_expected));
      if (scoreboard.size() != 0) begin
        t = scoreboard.pop_front();
        check({t.tag, "_hilo"}, {bus.hi, bus.lo}, t.exp);
        check({t.tag, "_latency"}, 64'(cyc - t.launch), 64'(W + 2));
        check({t.tag, "_busy_low"}, 64'(bus.busy), 64'(0));
      end
    end
  end

  task automatic comb(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input logic [31:0] exp_res, input logic exp_ovf,
                      input string tag);
    @(negedge clk);
    bus.opSel = op; bus.operand1 = a; bus.operand2 = b; bus.shamt = sh;
    #1;
    check(tag, 64'(bus.result), 64'(exp_res));
    check({tag, "_ovf"}, 64'(bus.overflow), 64'(exp_ovf));
  endtask

  task automatic launch(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag);
    @(negedge clk);
    bus.opSel = op; bus.operand1 = a; bus.operand2 = b; bus.start = 1'b1;
    scoreboard.push_back('{tag, exp, cyc + 1});
    done_expected++;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy"}, 64'(bus.busy), 64'(1));
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (scoreboard.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pending"}, 64'(scoreboard.size()), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  op;
    logic [31:0] ra, rb;
    bus.operand1 = '0; bus.operand2 = '0; bus.shamt = '0; bus.opSel = '0; bus.start = 1'b0;
    #12;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_hi",   64'(bus.hi),   64'(0));
    check("rst_lo",   64'(bus.lo),   64'(0));
    @(negedge clk);
    rst = 1'b1;

    comb(5'd10, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, "sra");
    comb(5'd11, 32'h1, 32'hFFFF_FFFF, 5'd0, 32'h1, 1'b0, "sltu");
    comb(5'd4,  32'h5, 32'h5,         5'd0, 32'h0, 1'b0, "slt_equal");
    comb(5'd4,  32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0, "slt_neg");
    comb(5'd5,  32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b0, "sgt_neg");
    comb(5'd0,  32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, SIGNED_OVF, "add_maxpos");
    comb(5'd0,  32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, ~SIGNED_OVF, "add_wrap");
    comb(5'd1,  32'h3, 32'h5,         5'd0, 32'hFFFF_FFFE, ~SIGNED_OVF, "sub_borrow");
    comb(5'd1,  32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, SIGNED_OVF, "sub_minneg");
    comb(5'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b0, "and");
    comb(5'd3,  32'hF0F0_F0F0, 32'h0F00_0000, 5'd0, 32'hFFF0_F0F0, 1'b0, "or");
    comb(5'd6,  32'h0, 32'h0,         5'd0, 32'hFFFF_FFFF, 1'b0, "nor");
    comb(5'd7,  32'hAAAA_5555, 32'hFFFF_0000, 5'd0, 32'h5555_5555, 1'b0, "xor");
    comb(5'd8,  32'h0, 32'h1,         5'd31, 32'h8000_0000, 1'b0, "sll");
    comb(5'd9,  32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, "srl");
    comb(5'd12, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b0, "mdu_code_zero");
    comb(5'd20, 32'hFFFF_FFFF, 32'h1, 5'd3, 32'h0, 1'b0, "unused_code");

    launch(5'd12, 32'hFFFF_FFFE, 32'h3, 64'hFFFF_FFFF_FFFF_FFFA, "mult");
    wait_drain("mult");
    comb(5'd16, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, "mfhi");
    comb(5'd17, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFA, 1'b0, "mflo");

    launch(5'd13, 32'hFFFF_FFFE, 32'h3, 64'h0000_0002_FFFF_FFFA, "multu");
    comb(5'd16, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, "mfhi_busy_old");
    wait_drain("multu");

    launch(5'd14, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD, "div_neg");
    wait_drain("div_neg");
    launch(5'd15, 32'h7, 32'h0, 64'h0000_0007_FFFF_FFFF, "divu_zero");
    wait_drain("divu_zero");
    launch(5'd14, 32'hFFFF_FFFB, 32'h0, 64'hFFFF_FFFB_FFFF_FFFF, "div_zero");
    wait_drain("div_zero");
    launch(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_minneg");
    wait_drain("div_minneg");

    // second start one cycle after launch must be dropped
    launch(5'd15, 32'd100, 32'd7, {32'd2, 32'd14}, "divu_b2b");
    bus.opSel = 5'd12; bus.operand1 = 32'd5; bus.operand2 = 32'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain("divu_b2b");
    repeat (40) @(negedge clk);
    check("b2b_single_done", 64'(done_seen), 64'(done_expected));

    for (int i = 0; i < 8; i++) begin
      op = 5'(12 + $urandom_range(0, 3));
      ra = $urandom;
      case (i % 3)
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(1, 20));
        default: rb = 32'h0 - 32'($urandom_range(1, 20));
      endcase
      launch(op, ra, rb, model(op, ra, rb), $sformatf("rand%0d_op%0d", i, op));
      wait_drain("rand");
    end

    launch(5'd15, 32'd1000, 32'd3, {32'd1, 32'd333}, "divu_abort");
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_hi",   64'(bus.hi),   64'(0));
    check("abort_lo",   64'(bus.lo),   64'(0));
    scoreboard.delete();
    done_expected = done_seen;
    @(negedge clk);
    rst = 1'b1;
    repeat (45) @(negedge clk);
    check("abort_no_done", 64'(done_seen), 64'(done_expected));
    check("abort_lo_kept", 64'(bus.lo), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised next-generation execute-stage ALU for the pipelined core.
- Keeps single-cycle combinational arithmetic/logic/shift ops, widened in data width and selector space.
- Adds an iterative multiply/divide unit with HI/LO registers and a start/busy/done handshake.
- The hazard unit uses busy to stall the pipeline while a multiply or divide is in flight.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even, >= 8
- SEL_WIDTH, 5, opSel width; must be >= 5
- SHAMT_WIDTH, 5, shamt width; equals log2(DATA_WIDTH)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- operand1  input  DATA_WIDTH  rs operand / dividend / multiplicand
- operand2  input  DATA_WIDTH  rt operand / divisor / multiplier
- shamt  input  SHAMT_WIDTH  shift amount
- opSel  input  SEL_WIDTH  operation select
- start  input  1  launch MDU op when opSel is MULT/MULTU/DIV/DIVU
- result  output  DATA_WIDTH  combinational result
- overflow  output  1  ADD/SUB overflow flag, combinational
- busy  output  1  MDU op in flight, registered
- done  output  1  one-cycle pulse when HI/LO are updated, registered
- hi  output  DATA_WIDTH  HI register
- lo  output  DATA_WIDTH  LO register

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed), 5 SGT (signed), 6 NOR, 7 XOR
  - 8 SLL, 9 SRL, 10 SRA: shift operand2 by shamt
  - 11 SLTU
  - 12 MULT, 13 MULTU, 14 DIV, 15 DIVU
  - 16 MFHI (result=hi), 17 MFLO (result=lo)
  - all other codes: result=0, overflow=0
- Codes 0-11 and 16-17 are purely combinational with zero latency; no state change.
- MDU opcodes (12-15) drive result=0 and overflow=0.
- Overflow is computed only for ADD/SUB; it is 0 for every other opcode.
- Reset (rst=0, async): FSM=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0.
- FSM states:
  - IDLE: start=1 with an MDU opcode latches operands, op and signedness. Signed ops store operand magnitudes and the result sign. Next state RUN, busy=1.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, DATA_WIDTH cycles, counter 0..DATA_WIDTH-1. Leaves to FIX after the last step.
  - FIX: apply sign correction; next state DONE.
  - DONE: write hi/lo, pulse done=1, busy=0; next state IDLE.
- Latency: start sampled at edge N; hi/lo updated and done=1 after edge N+DATA_WIDTH+2. busy is high for cycles N+1..N+DATA_WIDTH+1.
- start in IDLE with a non-MDU opcode: ignored.
- start while busy: ignored; no queueing, no restart.
- Operand changes after launch do not affect the in-flight op.
- Multiply result: {hi,lo} = full 2*DATA_WIDTH product; signed for MULT, unsigned for MULTU.
- Divide result: lo = quotient, hi = remainder.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero (DIV/DIVU): lo = all ones, hi = operand1; normal latency.
  - DIV of most-negative by -1: lo = most-negative, hi = 0.
- MFHI/MFLO while busy return the old hi/lo values. The stall logic prevents this use.
- Reset mid-operation aborts: hi/lo cleared, no done pulse.

Optional Feature:
- Macro: ALU_SIGNED_OVF_EN
- Defined: overflow = two's-complement signed overflow.
  - ADD: both operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from operand1.
- Undefined: overflow = unsigned carry-out (ADD) / borrow (SUB), i.e. bit DATA_WIDTH of the DATA_WIDTH+1-bit sum/difference.

Test Plan:
- Reset: assert rst=0 mid-RUN of a DIVU -> busy=0, done=0, hi=0, lo=0 immediately; no done pulse after release.
- Combinational ops:
  - SRA, operand2=0x80000000, shamt=4 -> result=0xF8000000
  - SLTU, 1 vs 0xFFFFFFFF -> 1
  - SLT, same operands -> 0
- MULT 0xFFFFFFFE × 3 (-2×3) -> done exactly 34 cycles after start edge; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start with DIVU 100/7; assert start with MULT 5×5 on the next cycle -> second start ignored; lo=14, hi=2; single done pulse.
- ADD 0x7FFFFFFF+1 -> result=0x80000000, overflow=1 with ALU_SIGNED_OVF_EN, 0 without.
- ADD 0xFFFFFFFF+1 -> overflow=0 with the macro, 1 without.
